// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer
//   Multi-cycle control FSM: walks one instruction at a time through FETCH, DECODE, EXEC,
//   MEM and WB. It drives the per-step datapath enables from the latched 7-bit opcode and
//   handshakes with the instruction and data memories using req/ack with a bounded wait.
//
// Ports
//   i_clk            clock, all state updates on the rising edge
//   i_rst            synchronous active-high reset
//   i_run            level: permission to start a new instruction
//   i_opcode[6:0]    instruction[6:0] from IR, valid from DECODE onward
//   i_branch_taken   ALU compare result, used in EXEC for BRANCH
//   i_imem_ack       instruction memory completed the fetch
//   i_dmem_ack       data memory completed the access
//   o_imem_req       fetch request, held until i_imem_ack
//   o_dmem_req       data request, held until i_dmem_ack
//   o_dmem_we        1 = store, 0 = load (valid with o_dmem_req)
//   o_ir_write       latch instruction into IR
//   o_pc_write       update PC
//   o_pc_src         0 = PC+4, 1 = branch target (valid with o_pc_write)
//   o_reg_write      regfile write strobe
//   o_alu_src        0 = rs2, 1 = immediate
//   o_alu_op[2:0]    000 = add/funct-decoded, 001 = subtract (branch compare)
//   o_mem_to_reg     WB data comes from memory
//   o_retire         one-cycle pulse when an instruction completes
//   o_busy           FSM is neither idle nor faulted
//   o_fault          sticky error flag (illegal opcode or memory timeout)

module multicycle_sequencer #(
    parameter int unsigned TIMEOUT = 16,  // max request cycles without ack; 0 disables
    parameter int unsigned CNT_W   = 5    // wait counter width, 2**CNT_W > TIMEOUT
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_run,
    input  logic [6:0] i_opcode,
    input  logic       i_branch_taken,
    input  logic       i_imem_ack,
    input  logic       i_dmem_ack,
    output logic       o_imem_req,
    output logic       o_dmem_req,
    output logic       o_dmem_we,
    output logic       o_ir_write,
    output logic       o_pc_write,
    output logic       o_pc_src,
    output logic       o_reg_write,
    output logic       o_alu_src,
    output logic [2:0] o_alu_op,
    output logic       o_mem_to_reg,
    output logic       o_retire,
    output logic       o_busy,
    output logic       o_fault
);

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;

    // Counter value seen during the last accepted request cycle.
    localparam bit                TimeoutEn   = (TIMEOUT != 0);
    localparam int unsigned       LastWaitInt = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0]  LastWait    = LastWaitInt[CNT_W-1:0];
    localparam logic [CNT_W-1:0]  WaitOne     = CNT_W'(1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StFault
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [6:0]       r_op;
    logic [CNT_W-1:0] r_wait;
    logic [CNT_W-1:0] w_wait_next;

    logic   w_is_imm;
    logic   w_is_load;
    logic   w_is_store;
    logic   w_is_branch;
    logic   w_opcode_legal;
    logic   w_timeout;
    state_t w_after_retire;

    // Type decode of the latched opcode; only meaningful from EXEC onward.
    assign w_is_imm    = (r_op == OpI);
    assign w_is_load   = (r_op == OpLoad);
    assign w_is_store  = (r_op == OpStore);
    assign w_is_branch = (r_op == OpBranch);

    // Legality is judged on the live IR value during DECODE, before it is latched.
    assign w_opcode_legal = (i_opcode == OpR)     || (i_opcode == OpI)     ||
                            (i_opcode == OpLoad)  || (i_opcode == OpStore) ||
                            (i_opcode == OpBranch);

    // Asserted in the last request cycle that may still accept an ack.
    assign w_timeout = TimeoutEn && (r_wait == LastWait);

    assign w_after_retire = i_run ? StFetch : StIdle;

    always_comb begin
        w_state_next = r_state;
        w_wait_next  = r_wait;
        o_imem_req   = 1'b0;
        o_dmem_req   = 1'b0;
        o_dmem_we    = 1'b0;
        o_ir_write   = 1'b0;
        o_pc_write   = 1'b0;
        o_pc_src     = 1'b0;
        o_reg_write  = 1'b0;
        o_alu_src    = 1'b0;
        o_alu_op     = AluAdd;
        o_mem_to_reg = 1'b0;
        o_retire     = 1'b0;
        o_busy       = 1'b0;
        o_fault      = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (i_run) begin
                    w_state_next = StFetch;
                end
            end

            StFetch: begin
                o_busy     = 1'b1;
                o_imem_req = 1'b1;
                if (i_imem_ack) begin
                    o_ir_write   = 1'b1;
                    w_state_next = StDecode;
                end else if (w_timeout) begin
                    w_state_next = StFault;
                end else begin
                    w_wait_next = r_wait + WaitOne;
                end
            end

            StDecode: begin
                o_busy       = 1'b1;
                w_state_next = w_opcode_legal ? StExec : StFault;
            end

            StExec: begin
                o_busy    = 1'b1;
                o_alu_src = w_is_imm || w_is_load || w_is_store;
                o_alu_op  = w_is_branch ? AluSub : AluAdd;
                if (w_is_branch) begin
                    // Branches resolve and retire here; no MEM or WB step.
                    o_pc_write   = 1'b1;
                    o_pc_src     = i_branch_taken;
                    o_retire     = 1'b1;
                    w_state_next = w_after_retire;
                end else if (w_is_load || w_is_store) begin
                    w_state_next = StMem;
                end else begin
                    w_state_next = StWb;
                end
            end

            StMem: begin
                o_busy     = 1'b1;
                o_dmem_req = 1'b1;
                o_dmem_we  = w_is_store;
                o_alu_src  = 1'b1;
                if (i_dmem_ack) begin
                    if (w_is_store) begin
                        // Stores have nothing to write back, so they retire on the ack.
                        o_pc_write   = 1'b1;
                        o_retire     = 1'b1;
                        w_state_next = w_after_retire;
                    end else begin
                        w_state_next = StWb;
                    end
                end else if (w_timeout) begin
                    w_state_next = StFault;
                end else begin
                    w_wait_next = r_wait + WaitOne;
                end
            end

            StWb: begin
                o_busy       = 1'b1;
                o_reg_write  = 1'b1;
                o_mem_to_reg = w_is_load;
                o_pc_write   = 1'b1;
                o_retire     = 1'b1;
                w_state_next = w_after_retire;
            end

            StFault: begin
                o_fault = 1'b1;
            end

            default: begin
                w_state_next = StFault;
            end
        endcase

        // Every new memory request starts its wait budget from zero.
        if ((w_state_next != r_state) &&
            ((w_state_next == StFetch) || (w_state_next == StMem))) begin
            w_wait_next = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_op    <= '0;
            r_wait  <= '0;
        end else begin
            r_state <= w_state_next;
            r_wait  <= w_wait_next;
            if (r_state == StDecode) begin
                r_op <= i_opcode;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer. Each instruction is expanded into a
// cycle-by-cycle list of stimulus and expected outputs, derived from the step rules
// (FETCH/DECODE/EXEC/MEM/WB), then replayed against the DUT.

module tb_multicycle_sequencer;

    localparam int unsigned TO = 4;
    localparam int unsigned CW = 3;

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;

    localparam int KR = 0, KI = 1, KL = 2, KS = 3, KB = 4, KIll = 5;
    localparam int PhReset = 0, PhIdle = 1, PhFetch = 2, PhDecode = 3, PhExec = 4,
                   PhMem = 5, PhWb = 6, PhFault = 7;

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       dmem_we;
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic       reg_write;
        logic       alu_src;
        logic [2:0] alu_op;
        logic       mem_to_reg;
        logic       retire;
        logic       busy;
        logic       fault;
    } out_t;

    typedef struct {
        logic       rst;
        logic       run;
        logic [6:0] opc;
        logic       bt;
        logic       iack;
        logic       dack;
        out_t       exp;
        int         ph;
        int         id;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst, run, branch_taken, imem_ack, dmem_ack;
    logic [6:0] opcode;
    logic       imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src, reg_write, alu_src;
    logic [2:0] alu_op;
    logic       mem_to_reg, retire, busy, fault;
    out_t       outs;

    ent_t q[$];
    bit   m_idle;
    int   instr_id;
    int   n_checks;
    int   n_errors;

    always #5 clk = ~clk;

    assign outs = '{imem_req: imem_req, dmem_req: dmem_req, dmem_we: dmem_we,
                    ir_write: ir_write, pc_write: pc_write, pc_src: pc_src,
                    reg_write: reg_write, alu_src: alu_src, alu_op: alu_op,
                    mem_to_reg: mem_to_reg, retire: retire, busy: busy, fault: fault};

    multicycle_sequencer #(
        .TIMEOUT(TO),
        .CNT_W  (CW)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_run         (run),
        .i_opcode      (opcode),
        .i_branch_taken(branch_taken),
        .i_imem_ack    (imem_ack),
        .i_dmem_ack    (dmem_ack),
        .o_imem_req    (imem_req),
        .o_dmem_req    (dmem_req),
        .o_dmem_we     (dmem_we),
        .o_ir_write    (ir_write),
        .o_pc_write    (pc_write),
        .o_pc_src      (pc_src),
        .o_reg_write   (reg_write),
        .o_alu_src     (alu_src),
        .o_alu_op      (alu_op),
        .o_mem_to_reg  (mem_to_reg),
        .o_retire      (retire),
        .o_busy        (busy),
        .o_fault       (fault)
    );

    function automatic int kind_of(input logic [6:0] op);
        case (op)
            OpR:      return KR;
            OpI:      return KI;
            OpLoad:   return KL;
            OpStore:  return KS;
            OpBranch: return KB;
            default:  return KIll;
        endcase
    endfunction

    function automatic string ph_name(input int ph);
        case (ph)
            PhReset:  return "reset";
            PhIdle:   return "idle";
            PhFetch:  return "fetch";
            PhDecode: return "decode";
            PhExec:   return "exec";
            PhMem:    return "mem";
            PhWb:     return "wb";
            default:  return "fault";
        endcase
    endfunction

    // Cycle with random don't-care inputs; callers pin whatever matters in that cycle.
    function automatic ent_t noise(input int ph);
        ent_t e;
        e.rst  = 1'b0;
        e.run  = 1'($urandom);
        e.opc  = 7'($urandom);
        e.bt   = 1'($urandom);
        e.iack = 1'($urandom);
        e.dack = 1'($urandom);
        e.exp  = '0;
        e.ph   = ph;
        e.id   = instr_id;
        return e;
    endfunction

    // FAULT holds regardless of run or late acks, until a reset.
    function automatic void push_fault();
        ent_t e;
        int   n;
        n = int'($urandom_range(2, 3));
        for (int c = 0; c < n; c++) begin
            e = noise(PhFault);
            if (c == 0) begin
                e.iack = 1'b1;
                e.dack = 1'b1;
            end
            e.exp.fault = 1'b1;
            q.push_back(e);
        end
        e = noise(PhFault);
        e.rst = 1'b1;
        e.exp.fault = 1'b1;
        q.push_back(e);
        m_idle = 1'b1;
    endfunction

    // Expands one instruction. wi/wd: ack-less request cycles before the ack (>= TO means
    // no ack ever). run_after is the run level seen when the instruction retires.
    function automatic void gen_instr(input logic [6:0] op, input int wi, input int wd,
                                      input bit run_after, input bit bt);
        ent_t e;
        int   k;
        int   n;
        k = kind_of(op);
        instr_id++;
        if (m_idle) begin
            n = int'($urandom_range(0, 2));
            for (int c = 0; c < n; c++) begin
                e = noise(PhIdle);
                e.run = 1'b0;
                q.push_back(e);
            end
            e = noise(PhIdle);
            e.run = 1'b1;
            q.push_back(e);
            m_idle = 1'b0;
        end
        for (int c = 0; c < wi && c < int'(TO); c++) begin
            e = noise(PhFetch);
            e.iack = 1'b0;
            e.exp.imem_req = 1'b1;
            e.exp.busy = 1'b1;
            q.push_back(e);
        end
        if (wi >= int'(TO)) begin
            push_fault();
            return;
        end
        e = noise(PhFetch);
        e.iack = 1'b1;
        e.exp.imem_req = 1'b1;
        e.exp.ir_write = 1'b1;
        e.exp.busy = 1'b1;
        q.push_back(e);

        e = noise(PhDecode);
        e.opc = op;
        e.exp.busy = 1'b1;
        q.push_back(e);
        if (k == KIll) begin
            push_fault();
            return;
        end

        e = noise(PhExec);
        e.bt = bt;
        if (!run_after) e.run = 1'b0;
        e.exp.busy = 1'b1;
        e.exp.alu_src = (k == KI) || (k == KL) || (k == KS);
        e.exp.alu_op = (k == KB) ? 3'b001 : 3'b000;
        if (k == KB) begin
            e.run = run_after;
            e.exp.pc_write = 1'b1;
            e.exp.pc_src = bt;
            e.exp.retire = 1'b1;
            q.push_back(e);
            m_idle = !run_after;
            return;
        end
        q.push_back(e);

        if (k == KL || k == KS) begin
            for (int c = 0; c < wd && c < int'(TO); c++) begin
                e = noise(PhMem);
                e.dack = 1'b0;
                e.exp.dmem_req = 1'b1;
                e.exp.dmem_we = (k == KS);
                e.exp.alu_src = 1'b1;
                e.exp.busy = 1'b1;
                q.push_back(e);
            end
            if (wd >= int'(TO)) begin
                push_fault();
                return;
            end
            e = noise(PhMem);
            e.dack = 1'b1;
            e.exp.dmem_req = 1'b1;
            e.exp.dmem_we = (k == KS);
            e.exp.alu_src = 1'b1;
            e.exp.busy = 1'b1;
            if (k == KS) begin
                e.run = run_after;
                e.exp.pc_write = 1'b1;
                e.exp.retire = 1'b1;
                q.push_back(e);
                m_idle = !run_after;
                return;
            end
            q.push_back(e);
        end

        e = noise(PhWb);
        e.run = run_after;
        e.exp.reg_write = 1'b1;
        e.exp.mem_to_reg = (k == KL);
        e.exp.pc_write = 1'b1;
        e.exp.retire = 1'b1;
        e.exp.busy = 1'b1;
        q.push_back(e);
        m_idle = !run_after;
    endfunction

    // Drives the next queued cycle and waits to the sampling point (negedge).
    task automatic apply_next(output ent_t e);
        e = q.pop_front();
        rst          = e.rst;
        run          = e.run;
        opcode       = e.opc;
        branch_taken = e.bt;
        imem_ack     = e.iack;
        dmem_ack     = e.dack;
        @(negedge clk);
    endtask

    task automatic test_reset();
        ent_t e;
        for (int c = 0; c < 3; c++) begin
            e = noise(PhReset);
            e.rst = 1'b1;
            e.run = 1'b1;
            q.push_back(e);
        end
        e = noise(PhIdle);
        e.run = 1'b1;
        q.push_back(e);
        m_idle = 1'b0;
        gen_instr(OpI, 0, 0, 1'b1, 1'b0);
        while (q.size() > 0) begin
            apply_next(e);
            n_checks++;
            if (outs !== e.exp) begin
                n_errors++;
                $display("FAIL test_reset %s instr=%0d got=%b want=%b",
                         ph_name(e.ph), e.id, outs, e.exp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_rtype_late_fetch();
        ent_t e;
        gen_instr(OpR, 2, 0, 1'b1, 1'b1);
        gen_instr(OpR, 3, 0, 1'b1, 1'b0);
        while (q.size() > 0) begin
            apply_next(e);
            n_checks++;
            if (outs !== e.exp) begin
                n_errors++;
                $display("FAIL test_rtype_late_fetch %s instr=%0d got=%b want=%b",
                         ph_name(e.ph), e.id, outs, e.exp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_load();
        ent_t e;
        gen_instr(OpLoad, 0, 2, 1'b1, 1'b0);
        gen_instr(OpLoad, 1, 3, 1'b1, 1'b1);
        while (q.size() > 0) begin
            apply_next(e);
            n_checks++;
            if (outs !== e.exp) begin
                n_errors++;
                $display("FAIL test_load %s instr=%0d got=%b want=%b",
                         ph_name(e.ph), e.id, outs, e.exp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_store_branch();
        ent_t e;
        gen_instr(OpStore, 0, 0, 1'b1, 1'b1);
        gen_instr(OpStore, 1, 2, 1'b1, 1'b0);
        gen_instr(OpBranch, 0, 0, 1'b1, 1'b1);
        gen_instr(OpBranch, 1, 0, 1'b1, 1'b0);
        while (q.size() > 0) begin
            apply_next(e);
            n_checks++;
            if (outs !== e.exp) begin
                n_errors++;
                $display("FAIL test_store_branch %s instr=%0d got=%b want=%b",
                         ph_name(e.ph), e.id, outs, e.exp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_faults();
        ent_t e;
        gen_instr(OpR, int'(TO), 0, 1'b1, 1'b0);
        gen_instr(7'b1111111, 0, 0, 1'b1, 1'b0);
        gen_instr(OpLoad, 0, int'(TO), 1'b1, 1'b0);
        gen_instr(OpI, 0, 0, 1'b1, 1'b0);
        while (q.size() > 0) begin
            apply_next(e);
            n_checks++;
            if (outs !== e.exp) begin
                n_errors++;
                $display("FAIL test_faults %s instr=%0d got=%b want=%b",
                         ph_name(e.ph), e.id, outs, e.exp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_run_drop();
        ent_t e;
        gen_instr(OpR, 0, 0, 1'b0, 1'b0);
        gen_instr(OpR, 0, 0, 1'b1, 1'b0);
        gen_instr(OpBranch, 0, 0, 1'b0, 1'b1);
        gen_instr(OpStore, 0, 1, 1'b0, 1'b0);
        gen_instr(OpI, 0, 0, 1'b1, 1'b0);
        while (q.size() > 0) begin
            apply_next(e);
            n_checks++;
            if (outs !== e.exp) begin
                n_errors++;
                $display("FAIL test_run_drop %s instr=%0d got=%b want=%b",
                         ph_name(e.ph), e.id, outs, e.exp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Reset lands in the middle of a data request; the request must drop without a retire.
    task automatic test_reset_abort();
        ent_t e;
        gen_instr(OpLoad, 0, int'(TO), 1'b1, 1'b0);
        // Replace the fault tail with an abort during the first MEM wait cycle.
        while (q.size() > 0 && q[q.size() - 1].ph != PhMem) begin
            void'(q.pop_back());
        end
        while (q.size() > 1 && q[q.size() - 2].ph == PhMem) begin
            void'(q.pop_back());
        end
        q[q.size() - 1].rst = 1'b1;
        m_idle = 1'b1;
        gen_instr(OpR, 0, 0, 1'b1, 1'b0);
        while (q.size() > 0) begin
            apply_next(e);
            n_checks++;
            if (outs !== e.exp) begin
                n_errors++;
                $display("FAIL test_reset_abort %s instr=%0d got=%b want=%b",
                         ph_name(e.ph), e.id, outs, e.exp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_random();
        ent_t       e;
        logic [6:0] op;
        int         sel;
        for (int n = 0; n < 60; n++) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                0, 1:    op = OpR;
                2:       op = OpI;
                3, 4:    op = OpLoad;
                5:       op = OpStore;
                6, 7:    op = OpBranch;
                default: begin
                    op = 7'($urandom);
                    while (kind_of(op) != KIll) op = 7'($urandom);
                end
            endcase
            if (sel == 9) begin
                gen_instr(OpStore, int'($urandom_range(0, 1)) * int'(TO), int'(TO),
                          1'b1, 1'b0);
            end else begin
                gen_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          ($urandom_range(0, 3) != 0), 1'($urandom));
            end
        end
        while (q.size() > 0) begin
            apply_next(e);
            n_checks++;
            if (outs !== e.exp) begin
                n_errors++;
                $display("FAIL test_random %s instr=%0d got=%b want=%b",
                         ph_name(e.ph), e.id, outs, e.exp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        instr_id     = 0;
        m_idle       = 1'b1;
        rst          = 1'b1;
        run          = 1'b1;
        opcode       = '0;
        branch_taken = 1'b0;
        imem_ack     = 1'b0;
        dmem_ack     = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_rtype_late_fetch();
        test_load();
        test_store_branch();
        test_faults();
        test_run_drop();
        test_reset_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
